// File: rtl/c2c_pkg.sv
// Shared definitions for the chip-to-chip link: top-level mode encodings
// and the receive-slave handshake state machine states.
package c2c_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_TX   = 2'd1;
   localparam logic [1:0] ST_RX   = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACK,
      S_WAIT_VALID,
      S_NOTICE,
      S_DONE,
      S_ERR
   } slaveState_e;

endpackage

// File: rtl/c2c_sync_fifo.sv
// Small synchronous FIFO that buffers received words for the local consumer.
// The head word is held in a register that is refreshed whenever the read
// pointer moves or a word is written into an empty slot at the read
// position. That slot is the head when the FIFO is empty, or when the only
// word is popped in the same cycle.
module c2c_sync_fifo
   import c2c_pkg::*;
#(
   parameter int DATA_W = 3,
   parameter int DEPTH  = 4
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_push,
   input  logic [DATA_W-1:0]        i_pushData,
   input  logic                     i_pop,
   output logic [DATA_W-1:0]        o_head,
   output logic                     o_notEmpty,
   output logic [$clog2(DEPTH):0]   o_fill
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wrPtr;
   logic [AW-1:0]     r_rdPtr;
   logic [AW:0]       r_fill;
   logic [DATA_W-1:0] r_head;

   logic              w_doPush;
   logic              w_doPop;
   logic [AW-1:0]     w_rdPtrNext;
   logic [DATA_W-1:0] w_headNext;

   // Qualify push/pop and work out which word will sit at the head next cycle
   always_comb begin
      w_doPop     = i_pop && (r_fill != '0);
      w_doPush    = i_push && ((r_fill != (AW+1)'(DEPTH)) || w_doPop);
      w_rdPtrNext = w_doPop ? (r_rdPtr + AW'(1)) : r_rdPtr;
      if (w_doPush && (w_rdPtrNext == r_wrPtr)) begin
         w_headNext = i_pushData;
      end else begin
         w_headNext = r_mem[w_rdPtrNext];
      end
   end

   // Storage array; contents need no reset because fill guards every read
   always_ff @(posedge i_clk) begin
      if (w_doPush) begin
         r_mem[r_wrPtr] <= i_pushData;
      end
   end

   // Pointers, occupancy and the registered head word
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_fill  <= '0;
         r_head  <= '0;
      end else begin
         if (w_doPush) begin
            r_wrPtr <= r_wrPtr + AW'(1);
         end
         r_rdPtr <= w_rdPtrNext;
         r_head  <= w_headNext;
         case ({w_doPush, w_doPop})
            2'b10:   r_fill <= r_fill + (AW+1)'(1);
            2'b01:   r_fill <= r_fill - (AW+1)'(1);
            default: r_fill <= r_fill;
         endcase
      end
   end

   assign o_head     = r_head;
   assign o_notEmpty = (r_fill != '0);
   assign o_fill     = r_fill;

endmodule

// File: rtl/c2c_slave_rx.sv
// Receive-side slave of the chip-to-chip link. Runs the four-phase
// request/ack/valid/notice handshake with the master one word at a time,
// checks even parity, and buffers accepted words for the local consumer.
// A full buffer holds the slave in IDLE so the master waits for space.
module c2c_slave_rx
   import c2c_pkg::*;
#(
   parameter int DATA_W     = 3,
   parameter int WORDS      = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int PARITY_EN  = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [1:0]                    top_state,
   input  logic                          request,
   input  logic                          valid,
   input  logic [DATA_W-1:0]             data_in,
   input  logic                          parity_in,
   output logic                          ack,
   output logic                          notice,
   output logic                          done,
   output logic                          err,
   output logic [DATA_W-1:0]             out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fill
);

   localparam int CW = $clog2(WORDS + 1);
   localparam int FW = $clog2(FIFO_DEPTH) + 1;

   logic [1:0]        r_reqSync;
   logic [1:0]        r_valSync;
   slaveState_e       r_state;
   logic [CW-1:0]     r_wordCnt;
   logic              r_ack;
   logic              r_notice;
   logic              r_done;
   logic              r_err;

   logic              w_reqS;
   logic              w_valS;
   logic              w_enabled;
   logic              w_parityBad;
   logic              w_push;
   logic [FW-1:0]     w_fill;

   // Two-stage synchronisers for the master's asynchronous strobes
   always_ff @(posedge clk) begin
      if (rst_n) begin
         r_reqSync <= '0;
         r_valSync <= '0;
      end else begin
         r_reqSync <= {r_reqSync[0], request};
         r_valSync <= {r_valSync[0], valid};
      end
   end

   // Word acceptance: a word enters the buffer in the cycle WAIT_VALID sees valid with good parity
   always_comb begin
      w_reqS      = r_reqSync[1];
      w_valS      = r_valSync[1];
      w_enabled   = (top_state == ST_RX);
      w_parityBad = (PARITY_EN != 0) && (^{data_in, parity_in});
      w_push      = (r_state == S_WAIT_VALID) && w_enabled && w_valS && !w_parityBad;
   end

   // Handshake state machine with registered, glitch-free outputs
   always_ff @(posedge clk) begin
      if (rst_n) begin
         r_state   <= S_IDLE;
         r_wordCnt <= '0;
         r_ack     <= 1'b0;
         r_notice  <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
      end else if (!w_enabled) begin
         r_state   <= S_IDLE;
         r_wordCnt <= '0;
         r_ack     <= 1'b0;
         r_notice  <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_reqS && (w_fill < FW'(FIFO_DEPTH))) begin
                  r_state <= S_ACK;
                  r_ack   <= 1'b1;
               end
            end
            S_ACK: begin
               if (!w_reqS) begin
                  r_state <= S_WAIT_VALID;
                  r_ack   <= 1'b0;
               end
            end
            S_WAIT_VALID: begin
               if (w_valS) begin
                  if (w_parityBad) begin
                     r_state <= S_ERR;
                     r_err   <= 1'b1;
                  end else begin
                     r_state   <= S_NOTICE;
                     r_notice  <= 1'b1;
                     r_wordCnt <= r_wordCnt + CW'(1);
                  end
               end
            end
            S_NOTICE: begin
               if (!w_valS) begin
                  r_notice <= 1'b0;
                  if (r_wordCnt == CW'(WORDS)) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end
            end
            S_DONE: begin
               r_wordCnt <= '0;
               r_state   <= S_IDLE;
            end
            S_ERR: begin
               r_state <= S_ERR;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   c2c_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .i_clk      (clk),
      .i_reset    (rst_n),
      .i_push     (w_push),
      .i_pushData (data_in),
      .i_pop      (out_ready),
      .o_head     (out_data),
      .o_notEmpty (out_valid),
      .o_fill     (w_fill)
   );

   assign ack    = r_ack;
   assign notice = r_notice;
   assign done   = r_done;
   assign err    = r_err;
   assign fill   = w_fill;

endmodule
